// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Recovers start / DATA_WIDTH data bits (LSB first) / optional parity / one stop
// bit from an idle-high serial line and reports each frame with one-cycle strobes.
// Optional build macro START_GLITCH_CHECK_EN: when defined, a start bit whose
// mid-bit majority sample reads 1 is treated as a glitch and the frame is dropped.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EW-1:0] EDGE_LAST   = EW'(OVERSAMPLE - 1);
    localparam logic [EW-1:0] EDGE_MID_LO = EW'(OVERSAMPLE / 2 - 1);
    localparam logic [EW-1:0] EDGE_MID    = EW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] EDGE_MID_HI = EW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [1:0]            syncChain;
    logic                  rxS;
    logic [2:0]            state;
    logic [EW-1:0]         edgeCnt;
    logic [BW-1:0]         bitCnt;
    logic [1:0]            midSamp;
    logic                  armed;
    logic                  parEnLat;
    logic                  parTypLat;
    logic                  parFail;
    logic                  stpFail;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [DATA_WIDTH-1:0] shiftNext;
    logic                  sampleBit;
    logic                  bitEnd;
    logic                  midPoint;
    logic                  parityBad;
    logic                  stopBad;

    assign rxS = syncChain[1];

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            syncChain <= 2'b11;
        end else begin
            syncChain <= {syncChain[0], RX_IN};
        end
    end

    // Majority vote, shift-register next value and the per-bit checks.
    always_comb begin
        bitEnd    = (edgeCnt == EDGE_LAST);
        midPoint  = (edgeCnt == EDGE_MID_HI);
        // Two earlier samples plus the live third sample at EDGE_MID_HI.
        sampleBit = (midSamp[0] & midSamp[1]) | (midSamp[0] & rxS) | (midSamp[1] & rxS);
        shiftNext = shiftReg >> 1;
        shiftNext[DATA_WIDTH-1] = sampleBit;
        parityBad = sampleBit ^ (^shiftReg) ^ parTypLat;
        // With OVERSAMPLE = 4 the third sample lands on the last edge of the
        // stop bit, so the registered flag would still be stale there.
        stopBad   = midPoint ? ~sampleBit : stpFail;
    end

    // Frame state machine, bit timing and outcome registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            edgeCnt    <= '0;
            bitCnt     <= '0;
            midSamp    <= 2'b11;
            armed      <= 1'b1;
            parEnLat   <= 1'b0;
            parTypLat  <= 1'b0;
            parFail    <= 1'b0;
            stpFail    <= 1'b0;
            shiftReg   <= '0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (edgeCnt == EDGE_MID_LO) begin
                midSamp[0] <= rxS;
            end
            if (edgeCnt == EDGE_MID) begin
                midSamp[1] <= rxS;
            end

            case (state)
                IDLE: begin
                    edgeCnt <= '0;
                    bitCnt  <= '0;
                    // A break leaves armed low until the line returns high.
                    if (rxS) begin
                        armed <= 1'b1;
                    end
                    if (armed && !rxS) begin
                        state     <= START;
                        parEnLat  <= PAR_EN;
                        parTypLat <= PAR_TYP;
                        parFail   <= 1'b0;
                        stpFail   <= 1'b0;
                    end
                end

                START: begin
                    edgeCnt <= bitEnd ? '0 : edgeCnt + 1'b1;
                    if (bitEnd) begin
                        state <= DATA;
                    end
`ifdef START_GLITCH_CHECK_EN
                    if (midPoint && sampleBit) begin
                        state   <= IDLE;
                        edgeCnt <= '0;
                    end
`endif
                end

                DATA: begin
                    edgeCnt <= bitEnd ? '0 : edgeCnt + 1'b1;
                    if (midPoint) begin
                        shiftReg <= shiftNext;
                    end
                    if (bitEnd) begin
                        if (bitCnt == BIT_LAST) begin
                            bitCnt <= '0;
                            state  <= parEnLat ? PARITY : STOP;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    edgeCnt <= bitEnd ? '0 : edgeCnt + 1'b1;
                    if (midPoint) begin
                        parFail <= parityBad;
                    end
                    if (bitEnd) begin
                        state <= STOP;
                    end
                end

                STOP: begin
                    edgeCnt <= bitEnd ? '0 : edgeCnt + 1'b1;
                    if (midPoint) begin
                        stpFail <= ~sampleBit;
                    end
                    if (bitEnd) begin
                        state      <= IDLE;
                        DATA_VALID <= ~parFail & ~stopBad;
                        PAR_ERR    <= parFail;
                        STP_ERR    <= stopBad;
                        if (~parFail & ~stopBad) begin
                            P_DATA <= shiftReg;
                        end
                        if (stopBad) begin
                            armed <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    edgeCnt <= '0;
                end
            endcase
        end
    end

endmodule
